uart_tx_fifo: RTL and testbench

- Serial transmitter that consumes the memory block's UART TX register outputs (`uart_tx_data`, `uart_tx_wen`) and drives the board's UART TX pin.
- Buffers CPU byte writes in a small FIFO, so back-to-back stores to 0xF000 are not lost while a frame is on the wire.
- Emits 8N1 frames, LSB first, at a fixed baud rate set by parameter.
- Exposes status (`busy`, `full`, `overflow`) for future memory-mapped readback.

---
 rtl/uart_tx_fifo.sv | 149 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a small byte FIFO; the CPU pushes bytes and the
// shifter drains them one frame at a time, LSB first.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wen,
  input  logic [7:0]         data,
  output logic               tx,
  output logic               busy,
  output logic               full,
  output logic [FIFO_AW:0]   count,
  output logic               overflow
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0]        BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   DEPTH_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

  state_t             state_q, state_d;
  logic [15:0]        baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic               push, pop, baud_done;

  // full is taken from the registered count, so a same-edge pop cannot rescue a push
  assign full      = (count_q == DEPTH_CNT);
  assign push      = wen & ~full;
  assign pop       = (state_q == IDLE) && (count_q != '0);
  assign baud_done = (baud_q == BAUD_LAST);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (wen & full);
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_done) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        baud_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; occupancy is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= data;
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE) | (count_q != '0);
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes, a line
// monitor decodes frames off tx and compares them in order.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int FRAME = 10 * CPB;

  logic          clk = 1'b0;
  logic          rst, wen, tx, busy, full, overflow;
  logic [7:0]    data;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
    .clk(clk), .rst(rst), .wen(wen), .data(data), .tx(tx),
    .busy(busy), .full(full), .count(count), .overflow(overflow)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         starts[$];
  int         cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // line monitor: k counts negedges since the first low sample of a frame
  logic       mon_active = 1'b0;
  logic       prev_tx = 1'b1;
  int         k = 0;
  logic [7:0] sh = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      mon_active = 1'b0;
    end else if (mon_active) begin
      k++;
      if (k == CPB / 2) begin
        check("start_bit", tx, 0);
      end else if (k > CPB && k < 9 * CPB && (k % CPB) == CPB / 2) begin
        sh[k / CPB - 1] = tx;
      end else if (k == 9 * CPB + CPB / 2) begin
        check("stop_bit", tx, 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got %02h expected no frame", sh);
        end else begin
          check("frame_byte", sh, exp_q.pop_front());
        end
      end else if (k == FRAME) begin
        check("idle_gap", tx, 1);
        mon_active = 1'b0;
      end
    end else if (tx === 1'b0 && prev_tx === 1'b1) begin
      mon_active = 1'b1;
      k = 0;
      starts.push_back(cyc);
    end
    prev_tx = tx;
  end

  task automatic push(input logic [7:0] b, input bit accepted);
    wen  = 1'b1;
    data = b;
    if (accepted) exp_q.push_back(b);
    @(posedge clk); #1;
    wen = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_drain: got busy=%0b pending=%0d expected idle with nothing pending",
               name, busy, exp_q.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wen = 1'b0; data = '0;
    step(2);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    step(1);

    // single byte 0xA5: exact start/stop timing
    push(8'hA5, 1);                      // E0
    check("t1_count_after_push", count, 1);
    check("t1_tx_before_pop", tx, 1);
    step(1);                             // E0+1
    check("t1_count_after_pop", count, 0);
    check("t1_tx_start", tx, 0);
    check("t1_busy", busy, 1);
    step(3);                             // E0+4
    check("t1_tx_start_end", tx, 0);
    step(1);                             // E0+5
    check("t1_tx_bit0", tx, 1);
    step(35);                            // E0+40
    check("t1_busy_stop", busy, 1);
    step(1);                             // E0+41
    check("t1_busy_done", busy, 0);
    check("t1_tx_idle", tx, 1);

    // three back-to-back bytes: order and 41-cycle frame spacing
    starts.delete();
    push(8'h31, 1);
    push(8'h32, 1);
    push(8'h33, 1);
    check("t2_count_peak", count, 2);
    drain("t2");
    check("t2_frames", starts.size(), 3);
    if (starts.size() >= 3) begin
      check("t2_spacing_a", starts[1] - starts[0], FRAME + 1);
      check("t2_spacing_b", starts[2] - starts[1], FRAME + 1);
    end

    // fill to full while the first frame is on the wire, then overflow
    for (int i = 0; i <= 16; i++) begin
      push(8'(i), 1);                    // E0+i
      if (i == 0) check("t3_count_first", count, 1);
      if (i == 1) check("t3_count_push_pop", count, 1);
    end
    check("t3_full", full, 1);
    check("t3_count_full", count, 16);
    check("t3_no_overflow_yet", overflow, 0);
    push(8'h11, 0);                      // E0+17, dropped
    check("t3_overflow", overflow, 1);
    check("t3_count_after_drop", count, 16);
    step(24);                            // E0+41: back in IDLE, still full
    check("t3_idle_tx", tx, 1);
    check("t3_idle_count", count, 16);
    push(8'hEE, 0);                      // E0+42: pop edge, push dropped
    check("t4_count_after_pop_edge", count, DEPTH - 1);
    check("t4_overflow", overflow, 1);
    check("t4_full_clear", full, 0);
    check("t4_tx_start", tx, 0);
    drain("t3");

    // reset during DATA bit 3 with two bytes queued
    push(8'h81, 1);                      // E0
    push(8'h82, 1);
    push(8'h83, 1);                      // E0+2
    check("t5_count_queued", count, 2);
    step(16);                            // E0+18
    rst = 1'b1;
    exp_q.delete();
    step(1);                             // E0+19: reset edge
    rst = 1'b0;
    check("t5_tx", tx, 1);
    check("t5_count", count, 0);
    check("t5_busy", busy, 0);
    check("t5_overflow", overflow, 0);
    check("t5_full", full, 0);
    step(2);
    push(8'h55, 1);
    drain("t5");
    step(FRAME);
    check("final_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
